edge_event_arbiter: RTL and testbench
=====================================

// Module: edge_event_arbiter
// PURPOSE
//  Multi-channel edge-event controller. Detects configurable edges on NUM_CH
//  single-bit inputs and latches each edge as a pending event. Events are
//  granted round-robin onto one valid/ready event port.
//  Sits between raw status/strobe lines and a single consumer (interrupt
//  logic or an event FIFO).
// PARAMETERS
//  NUM_CH  4               number of input channels (2..16)
//  CH_W    $clog2(NUM_CH)  width of channel index; derived, do not override
// PORTS
//  clk        in   1         clock; all logic on posedge
//  rst        in   1         reset, synchronous, active-high
//  sig_in     in   NUM_CH    input signals, already synchronous to clk
//  cfg_mode   in   2*NUM_CH  per-channel mode, ch i at [2i+1:2i]:
//                            00 off, 01 rise, 10 fall, 11 both
//  ev_valid   out  1         event available
//  ev_ready   in   1         consumer accepts the event when ev_valid&&ev_ready
//  ev_ch      out  CH_W      channel index of the presented event
//  ev_rise    out  1         1 = rising edge, 0 = falling edge
//  overflow   out  NUM_CH    sticky per channel: an edge was dropped
//  ovf_clr    in   1         clears all overflow bits
// BEHAVIOUR
//  Reset values:
//   - ev_valid, ev_ch, ev_rise and overflow are 0.
//   - Pending bits, sig_d and the round-robin pointer are 0.
//   - The prime flag is cleared.
//  Priming: on the first cycle after reset, sig_d <= sig_in and no edge is
//   detected. Detection starts from the second cycle.
//  Detection, per channel, every cycle:
//   - rise = sig_in & ~sig_d; fall = ~sig_in & sig_d; then sig_d <= sig_in.
//   - An edge counts only if enabled by cfg_mode, sampled in the same cycle.
//   - Mode 00 ignores new edges. A pending event on that channel stays
//     deliverable.
//  Pending: per channel, one pending bit plus a stored type.
//   - An edge with no pending event sets pending and stores the type.
//   - An edge while pending is dropped: the original event is kept and
//     overflow[i] is set.
//   - If a channel is granted in the same cycle a new edge arrives, pending
//     is re-armed with the new type and no overflow is raised.
//  Output slot, 2-state FSM:
//   - EMPTY -> FULL when any channel is pending.
//   - FULL -> EMPTY when ev_valid&&ev_ready and nothing is pending.
//   - FULL stays FULL when ev_valid&&ev_ready and a channel is pending: the
//     next winner loads in the same cycle. No bubble; 1 event/cycle maximum.
//   - While ev_valid && !ev_ready, ev_ch and ev_rise are held stable.
//  Arbitration: round-robin.
//   - The search starts at rr_ptr; the first pending channel at or above
//     rr_ptr wins, modulo NUM_CH.
//   - On a load, rr_ptr <= winner+1, wrapping from NUM_CH-1 to 0.
//   - Loading clears the winner's pending bit.
//  Latency: sig_in changes before clk edge k -> pending set at k -> ev_valid
//   high after k+1, if the slot is EMPTY or being accepted.
//  overflow:
//   - ovf_clr clears all bits.
//   - A set in the same cycle as ovf_clr wins, so that bit stays 1.
//  Reset mid-operation: all pending events, the output slot and overflow are
//   discarded; priming repeats.
// STRUCTURE
//  Package edge_evt_pkg:
//   - localparams MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10,
//     MODE_BOTH=2'b11.
//   - FSM state encoding S_EMPTY, S_FULL.
//  Sub-module edge_detect_cell, one per channel (generate loop):
//   - Holds sig_d, the prime gating, mode qualification, the pending bit,
//     the stored type and overflow[i].
//   - Outputs pending and pend_rise; inputs grant and ovf_clr.
//  Top level holds the round-robin picker, rr_ptr, the output slot FSM and
//  the output registers.
// TESTING
//  1. Reset with sig_in=4'b1111, release -> no event during priming; ev_valid
//     stays 0.
//  2. ch2 mode 01, 0->1 pulse, ev_ready=1 -> ev_valid for 1 cycle,
//     ev_ch=2, ev_rise=1, 2 cycles after the change.
//  3. All ch mode 11, all rise in the same cycle, ev_ready=1 -> events
//     ch0,1,2,3 on consecutive cycles; a following all-fall burst gives
//     0,1,2,3 again (rr_ptr wrapped).
//  4. ev_ready=0; ch1 rises then falls -> first event held stable,
//     overflow[1]=1 and the fall is lost; ovf_clr -> overflow=0.
//  5. ch0 mode 00 while pending, then ev_ready=1 -> the pending event is
//     still delivered; further edges give no events.
//  6. rst asserted with ev_valid=1 and 2 channels pending -> next cycle all
//     outputs 0; no stale events after release.

Source files
------------

// File: rtl/edge_event_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// edge_evt_pkg: edge-mode codes and output-slot state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package edge_evt_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/edge_event_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// edge_event_arbiter_if: valid/ready event port (channel index + edge type)
// Rev 1.0
// ----------------------------------------------------------------------------
interface edge_event_arbiter_if #(
  parameter int NUM_CH = 4
) ();
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            ev_valid;
  logic            ev_ready;
  logic [CH_W-1:0] ev_ch;
  logic            ev_rise;

  modport master (output ev_valid, output ev_ch, output ev_rise, input ev_ready);
  modport slave  (input ev_valid, input ev_ch, input ev_rise, output ev_ready);
endinterface
`default_nettype wire

// File: rtl/edge_event_arbiter_cell.sv
`default_nettype none
// ----------------------------------------------------------------------------
// edge_detect_cell: one channel's edge detector, pending event and overflow
// Rev 1.0
// ----------------------------------------------------------------------------
module edge_detect_cell
  import edge_evt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
  input  logic [1:0] mode,
  input  logic       grant,
  input  logic       ovf_clr,
  output logic       pending,
  output logic       pend_rise,
  output logic       overflow
);

  logic sig_d_q, sig_d_d;
  logic primed_q, primed_d;
  logic pend_q, pend_d;
  logic type_q, type_d;
  logic ovf_q, ovf_d;
  logic rise_en, fall_en, rise_hit, fall_hit, edge_hit;

  always_comb begin
    rise_en = 1'b0;
    fall_en = 1'b0;
    case (mode)
      MODE_OFF:  ;
      MODE_RISE: rise_en = 1'b1;
      MODE_FALL: fall_en = 1'b1;
      MODE_BOTH: begin
        rise_en = 1'b1;
        fall_en = 1'b1;
      end
      default: ;
    endcase

    // primed_q stays low for the first cycle after reset so the initial
    // sample of sig_in is never mistaken for an edge
    rise_hit = primed_q && rise_en && sig_in && !sig_d_q;
    fall_hit = primed_q && fall_en && !sig_in && sig_d_q;
    edge_hit = rise_hit || fall_hit;

    sig_d_d  = sig_in;
    primed_d = 1'b1;
    pend_d   = pend_q;
    type_d   = type_q;
    ovf_d    = ovf_q && !ovf_clr;

    if (grant) begin
      // slot is freed this cycle, so a coincident edge re-arms cleanly
      pend_d = edge_hit;
      if (edge_hit) type_d = rise_hit;
    end else if (edge_hit) begin
      if (pend_q) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = 1'b1;
        type_d = rise_hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_d_q  <= 1'b0;
      primed_q <= 1'b0;
      pend_q   <= 1'b0;
      type_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sig_d_q  <= sig_d_d;
      primed_q <= primed_d;
      pend_q   <= pend_d;
      type_q   <= type_d;
      ovf_q    <= ovf_d;
    end
  end

  assign pending   = pend_q;
  assign pend_rise = type_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// edge_event_arbiter: per-channel edge events, round-robin onto one event port
// Rev 1.0
// ----------------------------------------------------------------------------
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     sig_in,
  input  logic [2*NUM_CH-1:0]   cfg_mode,
  input  logic                  ovf_clr,
  output logic [NUM_CH-1:0]     overflow,
  edge_event_arbiter_if.master  ev
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int EW   = CH_W + 1;

  logic [NUM_CH-1:0] pending, pend_rise, grant;
  slot_state_t       state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   ev_ch_q, ev_ch_d;
  logic              ev_rise_q, ev_rise_d;
  logic [CH_W-1:0]   winner;
  logic [EW-1:0]     idx_ext;
  logic              found, any_pend, accept, load;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_detect_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (sig_in[i]),
      .mode      (cfg_mode[2*i+1:2*i]),
      .grant     (grant[i]),
      .ovf_clr   (ovf_clr),
      .pending   (pending[i]),
      .pend_rise (pend_rise[i]),
      .overflow  (overflow[i])
    );
  end

  // Round-robin search: first pending channel at or after rr_ptr, modulo NUM_CH
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    idx_ext = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_ext = {1'b0, rr_ptr_q} + EW'(i);
      if (idx_ext >= EW'(NUM_CH)) idx_ext = idx_ext - EW'(NUM_CH);
      if (!found && pending[idx_ext[CH_W-1:0]]) begin
        found  = 1'b1;
        winner = idx_ext[CH_W-1:0];
      end
    end
  end

  assign any_pend = |pending;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    ev_ch_d   = ev_ch_q;
    ev_rise_d = ev_rise_q;
    grant     = '0;
    accept    = (state_q == S_FULL) && ev.ev_ready;
    load      = 1'b0;

    case (state_q)
      S_EMPTY: begin
        if (any_pend) begin
          load    = 1'b1;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (accept) begin
          load    = any_pend;
          state_d = any_pend ? S_FULL : S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (load) begin
      grant[winner] = 1'b1;
      ev_ch_d       = winner;
      ev_rise_d     = pend_rise[winner];
      rr_ptr_d      = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      rr_ptr_q  <= '0;
      ev_ch_q   <= '0;
      ev_rise_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      ev_ch_q   <= ev_ch_d;
      ev_rise_q <= ev_rise_d;
    end
  end

  assign ev.ev_valid = (state_q == S_FULL);
  assign ev.ev_ch    = ev_ch_q;
  assign ev.ev_rise  = ev_rise_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_edge_event_arbiter: directed vector table plus randomized run vs. model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_edge_event_arbiter;

  localparam int NUM_CH = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_CH-1:0]   sig_in;
  logic [2*NUM_CH-1:0] cfg_mode;
  logic                ovf_clr;
  logic [NUM_CH-1:0]   overflow;

  edge_event_arbiter_if #(.NUM_CH(NUM_CH)) ev_if ();

  edge_event_arbiter #(.NUM_CH(NUM_CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .cfg_mode (cfg_mode),
    .ovf_clr  (ovf_clr),
    .overflow (overflow),
    .ev       (ev_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] sig;
    logic [7:0] mode;
    logic       rdy;
    logic       clr;
    logic       valid;
    logic [1:0] ch;
    logic       rise;
    logic [3:0] ovf;
    logic       cmp_ch;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  bit m_pend[NUM_CH];
  bit m_type[NUM_CH];
  bit m_prev[NUM_CH];
  bit m_ovf[NUM_CH];
  bit m_primed, m_valid, m_rise;
  int m_ch, m_ptr;

  function automatic void add(logic r, logic [3:0] s, logic [7:0] m, logic rd, logic c,
                              logic v, logic [1:0] ch, logic ri, logic [3:0] o, logic cc);
    vec_t t;
    t.rst = r; t.sig = s; t.mode = m; t.rdy = rd; t.clr = c;
    t.valid = v; t.ch = ch; t.rise = ri; t.ovf = o; t.cmp_ch = cc;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: one pending slot per channel, a single output slot, and a
  // rotating search origin; the grant is chosen from pre-edge pending state.
  task automatic model_step();
    bit accept, r, f, s;
    logic [1:0] md;
    int w, c;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_pend[i] = 0; m_type[i] = 0; m_prev[i] = 0; m_ovf[i] = 0;
      end
      m_primed = 0; m_valid = 0; m_ch = 0; m_rise = 0; m_ptr = 0;
      return;
    end
    accept = m_valid && ev_if.ev_ready;
    w = -1;
    if (!m_valid || accept) begin
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_ptr + k) % NUM_CH;
        if (w < 0 && m_pend[c]) w = c;
      end
    end
    if (w >= 0) begin
      m_valid = 1; m_ch = w; m_rise = m_type[w]; m_ptr = (w + 1) % NUM_CH;
    end else if (accept) begin
      m_valid = 0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      s  = sig_in[i];
      md = cfg_mode[2*i +: 2];
      r  = m_primed && s && !m_prev[i] && md[0];
      f  = m_primed && !s && m_prev[i] && md[1];
      if (ovf_clr) m_ovf[i] = 0;
      if (i == w) begin
        m_pend[i] = r || f;
        if (r || f) m_type[i] = r;
      end else if (r || f) begin
        if (m_pend[i]) m_ovf[i] = 1;
        else begin
          m_pend[i] = 1; m_type[i] = r;
        end
      end
      m_prev[i] = s;
    end
    m_primed = 1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] mo;
    rst = 1'b1; sig_in = '0; cfg_mode = '0; ovf_clr = 1'b0; ev_if.ev_ready = 1'b0;

    //   rst sig    mode   rdy clr  v  ch rise ovf  cmp_ch
    // reset with all inputs high, then priming: no event
    add(1, 4'hF, 8'hFF, 1, 0,  0, 0, 0, 4'h0, 1);
    add(1, 4'hF, 8'hFF, 1, 0,  0, 0, 0, 4'h0, 1);
    add(0, 4'hF, 8'hFF, 1, 0,  0, 0, 0, 4'h0, 1);
    add(0, 4'hF, 8'hFF, 1, 0,  0, 0, 0, 4'h0, 1);
    add(0, 4'hF, 8'hFF, 1, 0,  0, 0, 0, 4'h0, 1);
    // ch2 rise-only: fall ignored, rise seen two edges later for one cycle
    add(0, 4'hB, 8'h10, 1, 0,  0, 0, 0, 4'h0, 1);
    add(0, 4'hF, 8'h10, 1, 0,  0, 0, 0, 4'h0, 1);
    add(0, 4'hF, 8'h10, 1, 0,  1, 2, 1, 4'h0, 0);
    add(0, 4'hF, 8'h10, 1, 0,  0, 0, 0, 4'h0, 0);
    // reset, then all-rise burst and all-fall burst, round-robin 0..3 twice
    add(1, 4'h0, 8'h00, 1, 0,  0, 0, 0, 4'h0, 1);
    add(0, 4'h0, 8'h00, 1, 0,  0, 0, 0, 4'h0, 1);
    add(0, 4'hF, 8'hFF, 1, 0,  0, 0, 0, 4'h0, 1);
    add(0, 4'hF, 8'hFF, 1, 0,  1, 0, 1, 4'h0, 0);
    add(0, 4'hF, 8'hFF, 1, 0,  1, 1, 1, 4'h0, 0);
    add(0, 4'hF, 8'hFF, 1, 0,  1, 2, 1, 4'h0, 0);
    add(0, 4'h0, 8'hFF, 1, 0,  1, 3, 1, 4'h0, 0);
    add(0, 4'h0, 8'hFF, 1, 0,  1, 0, 0, 4'h0, 0);
    add(0, 4'h0, 8'hFF, 1, 0,  1, 1, 0, 4'h0, 0);
    add(0, 4'h0, 8'hFF, 1, 0,  1, 2, 0, 4'h0, 0);
    add(0, 4'h0, 8'hFF, 1, 0,  1, 3, 0, 4'h0, 0);
    add(0, 4'h0, 8'hFF, 1, 0,  0, 0, 0, 4'h0, 0);
    // backpressure: slot held, ch1 rise pending, ch1 fall dropped, then clear
    add(0, 4'h1, 8'hFF, 0, 0,  0, 0, 0, 4'h0, 0);
    add(0, 4'h3, 8'hFF, 0, 0,  1, 0, 1, 4'h0, 0);
    add(0, 4'h3, 8'hFF, 0, 0,  1, 0, 1, 4'h0, 0);
    add(0, 4'h1, 8'hFF, 0, 0,  1, 0, 1, 4'h2, 0);
    add(0, 4'h1, 8'hFF, 0, 1,  1, 0, 1, 4'h0, 0);
    add(0, 4'h1, 8'hFF, 1, 0,  1, 1, 1, 4'h0, 0);
    add(0, 4'h1, 8'hFF, 1, 0,  0, 0, 0, 4'h0, 0);
    // ch0 switched off while pending: still delivered, later edges ignored
    add(0, 4'h4, 8'hFF, 0, 0,  0, 0, 0, 4'h0, 0);
    add(0, 4'h4, 8'hFC, 0, 0,  1, 2, 1, 4'h0, 0);
    add(0, 4'h5, 8'hFC, 0, 0,  1, 2, 1, 4'h0, 0);
    add(0, 4'h5, 8'hFC, 1, 0,  1, 0, 0, 4'h0, 0);
    add(0, 4'h4, 8'hFC, 1, 0,  0, 0, 0, 4'h0, 0);
    add(0, 4'h5, 8'hFC, 1, 0,  0, 0, 0, 4'h0, 0);
    add(0, 4'h5, 8'hFC, 1, 0,  0, 0, 0, 4'h0, 0);
    // overflow set coinciding with ovf_clr keeps the bit
    add(0, 4'h1, 8'hFC, 0, 0,  0, 0, 0, 4'h0, 0);
    add(0, 4'h3, 8'hFC, 0, 0,  1, 2, 0, 4'h0, 0);
    add(0, 4'h1, 8'hFC, 0, 1,  1, 2, 0, 4'h2, 0);
    add(0, 4'h1, 8'hFC, 0, 0,  1, 2, 0, 4'h2, 0);
    add(0, 4'h9, 8'hFC, 0, 0,  1, 2, 0, 4'h2, 0);
    // reset with a full slot and two pending channels: nothing survives
    add(1, 4'h9, 8'hFC, 0, 0,  0, 0, 0, 4'h0, 1);
    add(0, 4'h9, 8'hFC, 1, 0,  0, 0, 0, 4'h0, 1);
    add(0, 4'h9, 8'hFC, 1, 0,  0, 0, 0, 4'h0, 1);
    add(0, 4'h9, 8'hFC, 1, 0,  0, 0, 0, 4'h0, 1);
    add(0, 4'h9, 8'hFC, 1, 0,  0, 0, 0, 4'h0, 1);

    for (int n = 0; n < vecs.size(); n++) begin
      rst = vecs[n].rst; sig_in = vecs[n].sig; cfg_mode = vecs[n].mode;
      ev_if.ev_ready = vecs[n].rdy; ovf_clr = vecs[n].clr;
      cycle();
      check($sformatf("row%0d valid", n), 32'(ev_if.ev_valid), 32'(vecs[n].valid));
      check($sformatf("row%0d overflow", n), 32'(overflow), 32'(vecs[n].ovf));
      if (vecs[n].valid || vecs[n].cmp_ch) begin
        check($sformatf("row%0d ev_ch", n), 32'(ev_if.ev_ch), 32'(vecs[n].ch));
        check($sformatf("row%0d ev_rise", n), 32'(ev_if.ev_rise), 32'(vecs[n].rise));
      end
    end

    cfg_mode = 8'hFF;
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      sig_in = sig_in ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) cfg_mode = 8'($urandom);
      ev_if.ev_ready = ($urandom_range(0, 3) >= (((n / 500) % 2 == 1) ? 3 : 1));
      ovf_clr = ($urandom_range(0, 15) == 0);
      cycle();
      for (int i = 0; i < NUM_CH; i++) mo[i] = m_ovf[i];
      check($sformatf("rand%0d valid", n), 32'(ev_if.ev_valid), 32'(m_valid));
      check($sformatf("rand%0d overflow", n), 32'(overflow), 32'(mo));
      if (m_valid) begin
        check($sformatf("rand%0d ev_ch", n), 32'(ev_if.ev_ch), 32'(m_ch));
        check($sformatf("rand%0d ev_rise", n), 32'(ev_if.ev_rise), 32'(m_rise));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
